switch_debounce_x3: RTL and testbench

//   Conditions the three raw slide-switch inputs before the 3-input majority voter.

---
 rtl/switch_debounce_x3_pkg.sv | 27 ++
 rtl/switch_debounce_x3_if.sv | 36 +++
 rtl/switch_debounce_x3_debounce_ch.sv | 70 +++++++
 rtl/switch_debounce_x3.sv | 48 ++++
 tb/tb_switch_debounce_x3.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/switch_debounce_x3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce_x3_pkg
// Brief   : Shared constants, per-edge action encoding and counter-width
//           helper for the three-channel switch debouncer.
// Revision: 1.0  initial release
// ============================================================================
package switch_debounce_x3_pkg;

  // The majority voter downstream needs exactly three inputs.
  localparam int SW_N_CH              = 3;
  localparam int SW_DEBOUNCE_CYCLES   = 16;

  // What a channel does at the next clock edge.
  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,  // synchronised level equals clean level
    ACT_COUNT  = 2'd1,  // new level seen, still counting
    ACT_ACCEPT = 2'd2   // terminal count reached, adopt new level
  } deb_action_e;

  // Counter must hold 0 .. DEBOUNCE_CYCLES.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_x3_if.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce_x3_if
// Brief   : Switch bundle between the raw switches and the voter-facing
//           debounced outputs.
// Revision: 1.0  initial release
// ============================================================================
interface switch_debounce_x3_if
  import switch_debounce_x3_pkg::*;
#(
  parameter int N_CH = SW_N_CH
);

  logic [N_CH-1:0] sw_raw;
  logic [N_CH-1:0] sw_clean;
  logic [N_CH-1:0] sw_changed;
  logic            all_stable;

  // Board/bench side: drives the raw switches, observes conditioned levels.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_changed,
    input  all_stable
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_changed,
    output all_stable
  );

endinterface
`default_nettype wire

// File: rtl/switch_debounce_x3_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module  : debounce_ch
// Brief   : One switch channel: two-flop synchroniser, stability counter,
//           registered clean level and one-cycle change pulse.
// Revision: 1.0  initial release
// ============================================================================
module debounce_ch
  import switch_debounce_x3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(SW_DEBOUNCE_CYCLES)
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  sw_raw,
  output logic sw_clean,
  output logic sw_changed,
  output logic cnt_zero
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  deb_action_e      action;

  // Decide the counter action from registered state only.
  always_comb begin
    action = ACT_IDLE;
    if (s2 != sw_clean) begin
      action = (cnt == TERM) ? ACT_ACCEPT : ACT_COUNT;
    end
  end

  // Synchroniser, stability counter and clean/changed registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      sw_clean   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      unique case (action)
        ACT_COUNT: begin
          cnt        <= cnt + CNT_W'(1);
          sw_changed <= 1'b0;
        end
        ACT_ACCEPT: begin
          sw_clean   <= s2;
          cnt        <= '0;
          sw_changed <= 1'b1;
        end
        default: begin
          // Any return to the clean level discards the partial count.
          cnt        <= '0;
          sw_changed <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/switch_debounce_x3.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce_x3
// Brief   : Synchronises and debounces the three slide switches feeding the
//           majority voter; flags when every channel is settled.
// Revision: 1.0  initial release
// ============================================================================
module switch_debounce_x3
  import switch_debounce_x3_pkg::*;
#(
  parameter int N_CH            = SW_N_CH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  wire                  clk,
  input  wire                  rst_n,
  switch_debounce_x3_if.slave  bus
);

  // Counter width follows from DEBOUNCE_CYCLES.
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [N_CH-1:0] clean_vec;
  logic [N_CH-1:0] changed_vec;
  logic [N_CH-1:0] zero_vec;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (bus.sw_raw[i]),
        .sw_clean   (clean_vec[i]),
        .sw_changed (changed_vec[i]),
        .cnt_zero   (zero_vec[i])
      );
    end
  endgenerate

  assign bus.sw_clean   = clean_vec;
  assign bus.sw_changed = changed_vec;
  // Decoded from the counters only, so no raw-input path reaches it.
  assign bus.all_stable = &zero_vec;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_x3.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_debounce_x3
// Brief   : Directed, table-driven bench for the three-channel debouncer with
//           DEBOUNCE_CYCLES=4, the debounced levels feeding a majority voter.
// Revision: 1.0  initial release
// ============================================================================
module tb_switch_debounce_x3;
  import switch_debounce_x3_pkg::*;

  localparam int D = 4;

  typedef struct {
    logic       rst_n;
    logic [2:0] raw;
    logic [2:0] clean;
    logic [2:0] chg;
    logic       stable;
    logic       vote;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t vecs[$];

  switch_debounce_x3_if #(.N_CH(SW_N_CH)) sw_if ();

  switch_debounce_x3 #(
    .N_CH            (SW_N_CH),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic void add(input logic r, input logic [2:0] raw,
                              input logic [2:0] clean, input logic [2:0] chg,
                              input logic st, input logic vote);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.clean = clean;
    v.chg = chg; v.stable = st; v.vote = vote;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge take them, sample 1 time unit later.
  task automatic step(input logic r, input logic [2:0] raw);
    rst_n = r;
    sw_if.sw_raw = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fire_at;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    sw_if.sw_raw = 3'b111;

    // Reset held for 3 edges with all switches up.
    for (int i = 0; i < 3; i++) add(0, 3'b111, 3'b000, 3'b000, 1, 0);
    // 000 -> 101: two sync edges, D counting edges, accept at edge 6.
    add(1, 3'b101, 3'b000, 3'b000, 1, 0);
    add(1, 3'b101, 3'b000, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b101, 3'b000, 3'b000, 0, 0);
    add(1, 3'b101, 3'b101, 3'b101, 1, 1);
    add(1, 3'b101, 3'b101, 3'b000, 1, 1);
    // 3-cycle high pulse on channel 1: count reaches D-1 then is discarded.
    add(1, 3'b111, 3'b101, 3'b000, 1, 1);
    add(1, 3'b111, 3'b101, 3'b000, 1, 1);
    add(1, 3'b111, 3'b101, 3'b000, 0, 1);
    add(1, 3'b101, 3'b101, 3'b000, 0, 1);
    add(1, 3'b101, 3'b101, 3'b000, 0, 1);
    add(1, 3'b101, 3'b101, 3'b000, 1, 1);
    // Bounce 1,0,1,0 on channel 0, then hold 0.
    add(1, 3'b101, 3'b101, 3'b000, 1, 1);
    add(1, 3'b100, 3'b101, 3'b000, 1, 1);
    add(1, 3'b101, 3'b101, 3'b000, 1, 1);
    add(1, 3'b100, 3'b101, 3'b000, 0, 1);
    add(1, 3'b100, 3'b101, 3'b000, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 3'b100, 3'b101, 3'b000, 0, 1);
    add(1, 3'b100, 3'b100, 3'b001, 1, 0);
    add(1, 3'b100, 3'b100, 3'b000, 1, 0);
    // Bring channel 2 down so all three can rise together.
    add(1, 3'b000, 3'b100, 3'b000, 1, 0);
    add(1, 3'b000, 3'b100, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b000, 3'b100, 3'b000, 0, 0);
    add(1, 3'b000, 3'b000, 3'b100, 1, 0);
    add(1, 3'b000, 3'b000, 3'b000, 1, 0);
    // 000 -> 111 on all channels: pulses coincide.
    add(1, 3'b111, 3'b000, 3'b000, 1, 0);
    add(1, 3'b111, 3'b000, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b111, 3'b000, 3'b000, 0, 0);
    add(1, 3'b111, 3'b111, 3'b111, 1, 1);
    add(1, 3'b111, 3'b111, 3'b000, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].raw);
      check("sw_clean",   i, sw_if.sw_clean,             vecs[i].clean);
      check("sw_changed", i, sw_if.sw_changed,           vecs[i].chg);
      check("all_stable", i, {2'b00, sw_if.all_stable},  {2'b00, vecs[i].stable});
      check("vote",       i, {2'b00, maj3(sw_if.sw_clean)}, {2'b00, vecs[i].vote});
    end

    // Reset during a pending 1->0 on channel 2 while its count is 2.
    for (int i = 0; i < 4; i++) step(1, 3'b011);
    check("mid_count_unstable", 100, {2'b00, sw_if.all_stable}, 3'b000);
    check("mid_count_clean",    101, sw_if.sw_clean, 3'b111);
    step(0, 3'b011);
    check("rst_clean",   102, sw_if.sw_clean,   3'b000);
    check("rst_changed", 103, sw_if.sw_changed, 3'b000);
    check("rst_stable",  104, {2'b00, sw_if.all_stable}, 3'b001);

    // After reset, channels 0/1 now differ from clean=0 and need a full
    // fresh count: the pulse must land on edge D+2 and no earlier.
    fire_at = 0;
    for (int e = 1; e <= 12 && fire_at == 0; e++) begin
      step(1, 3'b011);
      if (sw_if.sw_changed != 3'b000) fire_at = e;
    end
    check("fresh_count_edge", 105, fire_at[2:0], 3'(D + 2));
    check("fresh_changed",    106, sw_if.sw_changed, 3'b011);
    check("fresh_clean",      107, sw_if.sw_clean,   3'b011);
    step(1, 3'b011);
    check("fresh_pulse_end",  108, sw_if.sw_changed, 3'b000);
    check("fresh_vote",       109, {2'b00, maj3(sw_if.sw_clean)}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
